// File: rtl/fir_coef_load_ctrl_pkg.sv
// Shared types for the FIR coefficient load controller.
package fir_coef_load_ctrl_pkg;

  // Coefficient load sequencing states.
  typedef enum logic [1:0] {
    CL_IDLE    = 2'd0,
    CL_LOADING = 2'd1,
    CL_PENDING = 2'd2,
    CL_SWAP    = 2'd3
  } coef_load_state_type;

endpackage

// File: rtl/fir_coef_load_ctrl_bank.sv
// One coefficient bank: NTAPS x COEF_W registers, single write port,
// combinational read port that returns 0 for out-of-range indices.
module fir_coef_bank #(
  parameter int NTAPS  = 24,
  parameter int COEF_W = 27,
  parameter int ADDR_W = $clog2(NTAPS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [COEF_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [COEF_W-1:0] rdata_o
);

  logic [COEF_W-1:0] mem_q [NTAPS];

  // Coefficient storage, cleared on reset so no index ever reads X.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NTAPS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      for (int i = 0; i < NTAPS; i++) begin
        if (waddr_i == ADDR_W'(i)) begin
          mem_q[i] <= wdata_i;
        end
      end
    end
  end

  // Decoded read mux; indices beyond the last tap fall through to 0.
  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < NTAPS; i++) begin
      if (raddr_i == ADDR_W'(i)) begin
        rdata_o = mem_q[i];
      end
    end
  end

endmodule

// File: rtl/fir_coef_load_ctrl.sv
// FIR coefficient load controller: fills the shadow bank from the push
// stream and swaps banks only while the multiplier reports idle.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  CL_IDLE    | no load in progress; first push lands at shadow tap 0
//  CL_LOADING | collecting taps 1..NTAPS-1 into the shadow bank
//  CL_PENDING | full set held in shadow, waiting for swap_ok; pushes dropped
//  CL_SWAP    | one cycle: flip active bank; a push here starts the next set
module fir_coef_load_ctrl
  import fir_coef_load_ctrl_pkg::*;
#(
  parameter int   NTAPS  = 24,
  parameter int   COEF_W = 27,
  localparam int  ADDR_W = $clog2(NTAPS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PushCoef,
  input  logic [COEF_W-1:0] CoefIn,
  input  logic              swap_ok,
  input  logic [ADDR_W-1:0] coef_rd_addr,
  output logic [COEF_W-1:0] coef_rd_data,
  output logic              coef_ready,
  output logic              load_busy,
  output logic              active_bank,
  output logic              coef_overflow
);

  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(NTAPS - 1);

  coef_load_state_type state_q, state_d;
  logic [ADDR_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic                active_bank_q, active_bank_d;
  logic                coef_ready_q, coef_ready_d;
  logic                overflow_q, overflow_d;

  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic                wr_bank;
  logic [COEF_W-1:0]   rd_data0, rd_data1;

  // Controller state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= CL_IDLE;
      wr_cnt_q      <= '0;
      active_bank_q <= 1'b0;
      coef_ready_q  <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_cnt_q      <= wr_cnt_d;
      active_bank_q <= active_bank_d;
      coef_ready_q  <= coef_ready_d;
      overflow_q    <= overflow_d;
    end
  end

  // Next-state, write strobe and bank flip decisions.
  always_comb begin
    state_d       = state_q;
    wr_cnt_d      = wr_cnt_q;
    active_bank_d = active_bank_q;
    coef_ready_d  = coef_ready_q;
    overflow_d    = overflow_q;
    wr_en         = 1'b0;
    wr_addr       = wr_cnt_q;

    unique case (state_q)
      CL_IDLE: begin
        if (PushCoef) begin
          wr_en    = 1'b1;
          wr_addr  = '0;
          wr_cnt_d = ADDR_W'(1);
          state_d  = CL_LOADING;
        end
      end
      CL_LOADING: begin
        if (PushCoef) begin
          wr_en = 1'b1;
          if (wr_cnt_q == LAST_TAP) begin
            wr_cnt_d = '0;
            state_d  = CL_PENDING;
          end else begin
            wr_cnt_d = wr_cnt_q + ADDR_W'(1);
          end
        end
      end
      CL_PENDING: begin
        // The shadow set is complete; anything pushed now has nowhere to go.
        if (PushCoef) begin
          overflow_d = 1'b1;
        end
        if (swap_ok) begin
          state_d = CL_SWAP;
        end
      end
      CL_SWAP: begin
        active_bank_d = ~active_bank_q;
        coef_ready_d  = 1'b1;
        if (PushCoef) begin
          wr_en    = 1'b1;
          wr_addr  = '0;
          wr_cnt_d = ADDR_W'(1);
          state_d  = CL_LOADING;
        end else begin
          state_d  = CL_IDLE;
        end
      end
      default: begin
        state_d = CL_IDLE;
      end
    endcase
  end

  // During SWAP the bank flips at this same edge, so the new shadow is the
  // bank that is active right now.
  assign wr_bank = (state_q == CL_SWAP) ? active_bank_q : ~active_bank_q;

  fir_coef_bank #(
    .NTAPS  (NTAPS),
    .COEF_W (COEF_W),
    .ADDR_W (ADDR_W)
  ) u_bank0 (
    .clk     (clk),
    .reset   (reset),
    .we_i    (wr_en & ~wr_bank),
    .waddr_i (wr_addr),
    .wdata_i (CoefIn),
    .raddr_i (coef_rd_addr),
    .rdata_o (rd_data0)
  );

  fir_coef_bank #(
    .NTAPS  (NTAPS),
    .COEF_W (COEF_W),
    .ADDR_W (ADDR_W)
  ) u_bank1 (
    .clk     (clk),
    .reset   (reset),
    .we_i    (wr_en & wr_bank),
    .waddr_i (wr_addr),
    .wdata_i (CoefIn),
    .raddr_i (coef_rd_addr),
    .rdata_o (rd_data1)
  );

  assign coef_rd_data  = active_bank_q ? rd_data1 : rd_data0;
  assign coef_ready    = coef_ready_q;
  assign load_busy     = (state_q != CL_IDLE);
  assign active_bank   = active_bank_q;
  assign coef_overflow = overflow_q;

endmodule
